// File: rtl/gpc_4t_c2f_arb_if.sv
// rtl/gpc_4t_c2f_arb_if.sv - C2F fabric request/response channel between the arbiter and the fabric
interface gpc_4t_c2f_arb_if #(
    parameter int TID_W  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              C2F_ReqValidQ500H;
    logic [1:0]        C2F_ReqOpcodeQ500H;
    logic [TID_W-1:0]  C2F_ReqThreadIDQ500H;
    logic [ADDR_W-1:0] C2F_ReqAddressQ500H;
    logic [DATA_W-1:0] C2F_ReqDataQ500H;
    logic              C2F_RspStall;
    logic              C2F_RspValidQ502H;
    logic [1:0]        C2F_RspOpcodeQ502H;
    logic [TID_W-1:0]  C2F_RspThreadIDQ502H;
    logic [DATA_W-1:0] C2F_RspDataQ502H;

    modport master (
        output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
               C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
        input  C2F_RspStall, C2F_RspValidQ502H, C2F_RspOpcodeQ502H,
               C2F_RspThreadIDQ502H, C2F_RspDataQ502H
    );

    modport slave (
        input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
               C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
        output C2F_RspStall, C2F_RspValidQ502H, C2F_RspOpcodeQ502H,
               C2F_RspThreadIDQ502H, C2F_RspDataQ502H
    );
endinterface

// File: rtl/gpc_4t_c2f_arb.sv
// rtl/gpc_4t_c2f_arb.sv - 4-thread C2F request arbiter and outstanding-read tracker
module gpc_4t_c2f_arb #(
    parameter int NUM_THR     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      QClk,
    input  logic                      RstQnnnL,
    input  logic [NUM_THR-1:0]        ThrReqValid,
    input  logic [2*NUM_THR-1:0]      ThrReqOpcode,
    input  logic [ADDR_W*NUM_THR-1:0] ThrReqAddress,
    input  logic [DATA_W*NUM_THR-1:0] ThrReqData,
    output logic [NUM_THR-1:0]        ThrReqReady,
    gpc_4t_c2f_arb_if.master          c2f,
    output logic [NUM_THR-1:0]        ThrRspValid,
    output logic [DATA_W-1:0]         ThrRspData,
    output logic [NUM_THR-1:0]        ThrOutstanding,
    output logic [NUM_THR-1:0]        TimeoutErr,
    output logic                      SpuriousRsp
);
    localparam int TID_W = $clog2(NUM_THR);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0] OPC_RD = 2'b01;
    localparam logic [1:0] OPC_WR = 2'b10;

    // Per-thread request slots
    logic [NUM_THR-1:0] pend_q, pend_d;
    logic [1:0]         slot_opc_q  [NUM_THR];
    logic [1:0]         slot_opc_d  [NUM_THR];
    logic [ADDR_W-1:0]  slot_addr_q [NUM_THR];
    logic [ADDR_W-1:0]  slot_addr_d [NUM_THR];
    logic [DATA_W-1:0]  slot_data_q [NUM_THR];
    logic [DATA_W-1:0]  slot_data_d [NUM_THR];

    // Outstanding-read tracking and error flags
    logic [NUM_THR-1:0] outst_q, outst_d;
    logic [CNT_W-1:0]   cnt_q [NUM_THR];
    logic [CNT_W-1:0]   cnt_d [NUM_THR];
    logic [NUM_THR-1:0] terr_q, terr_d;
    logic               spur_q, spur_d;

    // Round-robin pointer and fabric output register
    logic [TID_W-1:0]   ptr_q, ptr_d;
    logic               req_valid_q, req_valid_d;
    logic [1:0]         req_opc_q, req_opc_d;
    logic [TID_W-1:0]   req_tid_q, req_tid_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [DATA_W-1:0]  req_data_q, req_data_d;

    // Registered read-return to the threads
    logic [NUM_THR-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic               out_free;
    logic               gnt_found;
    logic [TID_W-1:0]   gnt_idx;
    logic [TID_W-1:0]   scan_idx;
    logic [1:0]         gnt_opc;
    logic               rsp_hit;

    assign ThrReqReady = ~pend_q & ~outst_q;
    assign out_free    = ~req_valid_q | ~c2f.C2F_RspStall;
    assign gnt_opc     = slot_opc_q[gnt_idx];
    assign rsp_hit     = c2f.C2F_RspValidQ502H & outst_q[c2f.C2F_RspThreadIDQ502H]
                       & (c2f.C2F_RspOpcodeQ502H == OPC_RD);

    // Find the first pending thread at or after the round-robin pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_THR; i++) begin
            scan_idx = TID_W'((int'(ptr_q) + i) % NUM_THR);
            if (!gnt_found && pend_q[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Next-state: response routing, timeout counting, grant and slot accept
    always_comb begin
        pend_d      = pend_q;
        slot_opc_d  = slot_opc_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        outst_d     = outst_q;
        cnt_d       = cnt_q;
        terr_d      = terr_q;
        spur_d      = spur_q;
        ptr_d       = ptr_q;
        req_valid_d = req_valid_q;
        req_opc_d   = req_opc_q;
        req_tid_d   = req_tid_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        // A response only counts if its thread really has a read in flight
        if (c2f.C2F_RspValidQ502H) begin
            if (rsp_hit) begin
                rsp_valid_d[c2f.C2F_RspThreadIDQ502H] = 1'b1;
                rsp_data_d                            = c2f.C2F_RspDataQ502H;
                outst_d[c2f.C2F_RspThreadIDQ502H]     = 1'b0;
            end else begin
                spur_d = 1'b1;
            end
        end

        // Error fires on the cycle after the counter has sat at its limit,
        // so the read has been visible as outstanding for TIMEOUT_CYC cycles
        for (int t = 0; t < NUM_THR; t++) begin
            if (outst_q[t]) begin
                if (cnt_q[t] == CNT_MAX) begin
                    terr_d[t] = 1'b1;
                end else begin
                    cnt_d[t] = cnt_q[t] + CNT_W'(1);
                end
            end
        end

        // Illegal opcodes consume their grant turn but never reach the fabric
        if (out_free) begin
            req_valid_d = 1'b0;
            if (gnt_found) begin
                pend_d[gnt_idx] = 1'b0;
                ptr_d           = TID_W'((int'(gnt_idx) + 1) % NUM_THR);
                if (gnt_opc == OPC_RD || gnt_opc == OPC_WR) begin
                    req_valid_d = 1'b1;
                    req_opc_d   = gnt_opc;
                    req_tid_d   = gnt_idx;
                    req_addr_d  = slot_addr_q[gnt_idx];
                    req_data_d  = slot_data_q[gnt_idx];
                    if (gnt_opc == OPC_RD) begin
                        outst_d[gnt_idx] = 1'b1;
                        cnt_d[gnt_idx]   = '0;
                    end
                end
            end
        end

        // Ready is taken from pre-edge state, so a slot freed this cycle cannot refill yet
        for (int t = 0; t < NUM_THR; t++) begin
            if (ThrReqValid[t] && ThrReqReady[t]) begin
                pend_d[t]      = 1'b1;
                slot_opc_d[t]  = ThrReqOpcode[2*t +: 2];
                slot_addr_d[t] = ThrReqAddress[ADDR_W*t +: ADDR_W];
                slot_data_d[t] = ThrReqData[DATA_W*t +: DATA_W];
            end
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            pend_q      <= '0;
            slot_opc_q  <= '{default: '0};
            slot_addr_q <= '{default: '0};
            slot_data_q <= '{default: '0};
            outst_q     <= '0;
            cnt_q       <= '{default: '0};
            terr_q      <= '0;
            spur_q      <= 1'b0;
            ptr_q       <= '0;
            req_valid_q <= 1'b0;
            req_opc_q   <= '0;
            req_tid_q   <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            slot_opc_q  <= slot_opc_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            outst_q     <= outst_d;
            cnt_q       <= cnt_d;
            terr_q      <= terr_d;
            spur_q      <= spur_d;
            ptr_q       <= ptr_d;
            req_valid_q <= req_valid_d;
            req_opc_q   <= req_opc_d;
            req_tid_q   <= req_tid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign c2f.C2F_ReqValidQ500H    = req_valid_q;
    assign c2f.C2F_ReqOpcodeQ500H   = req_opc_q;
    assign c2f.C2F_ReqThreadIDQ500H = req_tid_q;
    assign c2f.C2F_ReqAddressQ500H  = req_addr_q;
    assign c2f.C2F_ReqDataQ500H     = req_data_q;
    assign ThrRspValid              = rsp_valid_q;
    assign ThrRspData               = rsp_data_q;
    assign ThrOutstanding           = outst_q;
    assign TimeoutErr               = terr_q;
    assign SpuriousRsp              = spur_q;
endmodule

// File: tb/tb_gpc_4t_c2f_arb.sv
// tb/tb_gpc_4t_c2f_arb.sv - scoreboard bench for gpc_4t_c2f_arb
module tb_gpc_4t_c2f_arb;
    localparam int NT = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic QClk = 1'b0;
    logic RstQnnnL = 1'b0;
    always #5 QClk = ~QClk;

    logic [NT-1:0]    ThrReqValid;
    logic [2*NT-1:0]  ThrReqOpcode;
    logic [AW*NT-1:0] ThrReqAddress;
    logic [DW*NT-1:0] ThrReqData;
    logic [NT-1:0]    ThrReqReady;
    logic [NT-1:0]    ThrRspValid;
    logic [DW-1:0]    ThrRspData;
    logic [NT-1:0]    ThrOutstanding;
    logic [NT-1:0]    TimeoutErr;
    logic             SpuriousRsp;

    gpc_4t_c2f_arb_if #(.TID_W(2), .ADDR_W(AW), .DATA_W(DW)) c2f ();

    gpc_4t_c2f_arb #(.NUM_THR(NT), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .QClk(QClk), .RstQnnnL(RstQnnnL),
        .ThrReqValid(ThrReqValid), .ThrReqOpcode(ThrReqOpcode),
        .ThrReqAddress(ThrReqAddress), .ThrReqData(ThrReqData),
        .ThrReqReady(ThrReqReady), .c2f(c2f),
        .ThrRspValid(ThrRspValid), .ThrRspData(ThrRspData),
        .ThrOutstanding(ThrOutstanding), .TimeoutErr(TimeoutErr),
        .SpuriousRsp(SpuriousRsp)
    );

    // Reference model: per-thread records plus a rotating priority index
    typedef struct {
        bit             pend;
        bit             outst;
        bit             terr;
        logic [1:0]     opc;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        int             age;
    } thr_t;
    typedef struct {
        logic [1:0]    opc;
        logic [1:0]    tid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;
    typedef struct {
        logic [NT-1:0] vec;
        logic [DW-1:0] data;
    } rsp_t;

    thr_t m_thr[NT];
    bit   m_spur;
    int   m_ptr;
    bit   m_busy;
    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_thr[t].pend = 0; m_thr[t].outst = 0; m_thr[t].terr = 0;
            m_thr[t].opc = '0; m_thr[t].addr = '0; m_thr[t].data = '0; m_thr[t].age = 0;
        end
        m_spur = 0;
        m_ptr  = 0;
        m_busy = 0;
        exp_req.delete();
        exp_rsp.delete();
    endtask

    // One clock edge of the rules, evaluated from the pre-edge picture
    task automatic model_step();
        thr_t pre[NT];
        bit   free_now;
        int   g;
        int   t;
        req_t rq;
        rsp_t rs;
        pre = m_thr;
        free_now = !m_busy || !c2f.C2F_RspStall;
        if (c2f.C2F_RspValidQ502H) begin
            t = int'(c2f.C2F_RspThreadIDQ502H);
            if (pre[t].outst && c2f.C2F_RspOpcodeQ502H == 2'b01) begin
                rs.vec = '0;
                rs.vec[t] = 1'b1;
                rs.data = c2f.C2F_RspDataQ502H;
                exp_rsp.push_back(rs);
                m_thr[t].outst = 0;
            end else begin
                m_spur = 1;
            end
        end
        for (int k = 0; k < NT; k++) begin
            if (pre[k].outst) begin
                if (pre[k].age >= TO - 1) m_thr[k].terr = 1;
                else m_thr[k].age = pre[k].age + 1;
            end
        end
        if (free_now) begin
            m_busy = 0;
            g = -1;
            for (int k = 0; k < NT; k++)
                if (g < 0 && pre[(m_ptr + k) % NT].pend) g = (m_ptr + k) % NT;
            if (g >= 0) begin
                m_thr[g].pend = 0;
                m_ptr = (g + 1) % NT;
                if (pre[g].opc == 2'b01 || pre[g].opc == 2'b10) begin
                    rq.opc = pre[g].opc; rq.tid = 2'(g); rq.addr = pre[g].addr; rq.data = pre[g].data;
                    exp_req.push_back(rq);
                    m_busy = 1;
                    if (pre[g].opc == 2'b01) begin
                        m_thr[g].outst = 1;
                        m_thr[g].age = 0;
                    end
                end
            end
        end
        for (int k = 0; k < NT; k++) begin
            if (ThrReqValid[k] && !pre[k].pend && !pre[k].outst) begin
                m_thr[k].pend = 1;
                m_thr[k].opc  = ThrReqOpcode[2*k +: 2];
                m_thr[k].addr = ThrReqAddress[AW*k +: AW];
                m_thr[k].data = ThrReqData[DW*k +: DW];
            end
        end
    endtask

    function automatic logic [NT-1:0] m_vec(input int which);
        logic [NT-1:0] v;
        v = '0;
        for (int k = 0; k < NT; k++) begin
            case (which)
                0: v[k] = !m_thr[k].pend && !m_thr[k].outst;
                1: v[k] = m_thr[k].outst;
                default: v[k] = m_thr[k].terr;
            endcase
        end
        return v;
    endfunction

    // Monitor: pops expectations whenever the DUT presents something new
    initial begin
        bit   prev_v;
        bit   consumed;
        bit   newp;
        req_t held;
        req_t e;
        rsp_t er;
        prev_v = 0;
        held = '{opc: '0, tid: '0, addr: '0, data: '0};
        forever begin
            @(posedge QClk);
            #1;
            if (!RstQnnnL) begin
                prev_v = 0;
                continue;
            end
            consumed = prev_v && !c2f.C2F_RspStall;
            newp = c2f.C2F_ReqValidQ500H && (!prev_v || consumed);
            if (newp) begin
                held.opc = c2f.C2F_ReqOpcodeQ500H; held.tid = c2f.C2F_ReqThreadIDQ500H;
                held.addr = c2f.C2F_ReqAddressQ500H; held.data = c2f.C2F_ReqDataQ500H;
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got tid %0d addr %0h expected no request", held.tid, held.addr);
                end else begin
                    e = exp_req.pop_front();
                    check("req_opc", c2f.C2F_ReqOpcodeQ500H, e.opc);
                    check("req_tid", c2f.C2F_ReqThreadIDQ500H, e.tid);
                    check("req_addr", c2f.C2F_ReqAddressQ500H, e.addr);
                    check("req_data", c2f.C2F_ReqDataQ500H, e.data);
                end
            end else begin
                if (exp_req.size() != 0) begin
                    e = exp_req.pop_front();
                    checks++; errors++;
                    $display("FAIL req_missing: got no new request expected tid %0d addr %0h", e.tid, e.addr);
                end
                if (c2f.C2F_ReqValidQ500H) begin
                    check("req_hold_opc", c2f.C2F_ReqOpcodeQ500H, held.opc);
                    check("req_hold_tid", c2f.C2F_ReqThreadIDQ500H, held.tid);
                    check("req_hold_addr", c2f.C2F_ReqAddressQ500H, held.addr);
                    check("req_hold_data", c2f.C2F_ReqDataQ500H, held.data);
                end
            end
            prev_v = c2f.C2F_ReqValidQ500H;

            if (ThrRspValid != '0) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got vec %b expected none", ThrRspValid);
                end else begin
                    er = exp_rsp.pop_front();
                    check("rsp_vec", ThrRspValid, er.vec);
                    check("rsp_data", ThrRspData, er.data);
                end
            end else if (exp_rsp.size() != 0) begin
                er = exp_rsp.pop_front();
                checks++; errors++;
                $display("FAIL rsp_missing: got none expected vec %b", er.vec);
            end

            check("ready", ThrReqReady, m_vec(0));
            check("outstanding", ThrOutstanding, m_vec(1));
            check("timeout", TimeoutErr, m_vec(2));
            check("spurious", SpuriousRsp, m_spur);
        end
    end

    task automatic idle();
        ThrReqValid = '0;
        c2f.C2F_RspStall = 1'b0;
        c2f.C2F_RspValidQ502H = 1'b0;
    endtask

    task automatic set_req(input int t, input logic [1:0] opc, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ThrReqValid[t] = 1'b1;
        ThrReqOpcode[2*t +: 2] = opc;
        ThrReqAddress[AW*t +: AW] = a;
        ThrReqData[DW*t +: DW] = d;
    endtask

    task automatic send_rsp(input int t, input logic [1:0] opc, input logic [DW-1:0] d);
        c2f.C2F_RspValidQ502H = 1'b1;
        c2f.C2F_RspThreadIDQ502H = 2'(t);
        c2f.C2F_RspOpcodeQ502H = opc;
        c2f.C2F_RspDataQ502H = d;
    endtask

    task automatic step();
        @(posedge QClk);
        if (RstQnnnL) model_step();
        @(negedge QClk);
    endtask

    // Reset between clock edges and confirm outputs clear without a clock
    task automatic do_reset();
        #2;
        RstQnnnL = 1'b0;
        #1;
        check("rst_req_valid", c2f.C2F_ReqValidQ500H, 0);
        check("rst_req_opc", c2f.C2F_ReqOpcodeQ500H, 0);
        check("rst_req_tid", c2f.C2F_ReqThreadIDQ500H, 0);
        check("rst_req_addr", c2f.C2F_ReqAddressQ500H, 0);
        check("rst_req_data", c2f.C2F_ReqDataQ500H, 0);
        check("rst_rsp_valid", ThrRspValid, 0);
        check("rst_rsp_data", ThrRspData, 0);
        check("rst_outstanding", ThrOutstanding, 0);
        check("rst_timeout", TimeoutErr, 0);
        check("rst_spurious", SpuriousRsp, 0);
        check("rst_ready", ThrReqReady, 4'hF);
        check("rst_req_queue_empty", exp_req.size(), 0);
        check("rst_rsp_queue_empty", exp_rsp.size(), 0);
        model_reset();
        idle();
        @(negedge QClk);
        RstQnnnL = 1'b1;
    endtask

    task automatic rand_cycle();
        int cand[$];
        int r;
        for (int t = 0; t < NT; t++) begin
            if ($urandom_range(0, 99) < 40) begin
                r = int'($urandom_range(0, 19));
                set_req(t, (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 11) ? 2'b01 : 2'b10, $urandom, $urandom);
            end else begin
                ThrReqValid[t] = 1'b0;
            end
        end
        c2f.C2F_RspStall = ($urandom_range(0, 99) < 30);
        c2f.C2F_RspValidQ502H = 1'b0;
        if ($urandom_range(0, 99) < 35) begin
            for (int k = 0; k < NT; k++) if (m_thr[k].outst) cand.push_back(k);
            if (cand.size() > 0 && $urandom_range(0, 39) != 0)
                send_rsp(cand[$urandom_range(0, cand.size() - 1)], 2'b01, $urandom);
            else
                send_rsp(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
        end
        step();
    endtask

    initial begin
        int order2[4] = '{1, 2, 3, 0};
        ThrReqValid = '0; ThrReqOpcode = '0; ThrReqAddress = '0; ThrReqData = '0;
        c2f.C2F_RspStall = 1'b0; c2f.C2F_RspValidQ502H = 1'b0;
        c2f.C2F_RspOpcodeQ502H = '0; c2f.C2F_RspThreadIDQ502H = '0; c2f.C2F_RspDataQ502H = '0;
        model_reset();
        repeat (2) @(negedge QClk);
        check("init_ready", ThrReqReady, 4'hF);
        check("init_req_valid", c2f.C2F_ReqValidQ500H, 0);
        RstQnnnL = 1'b1;

        // Round-robin from pointer 0, then from pointer 1
        for (int t = 0; t < NT; t++) set_req(t, 2'b10, 32'h1000 + t, 32'hA0 + t);
        step(); idle();
        for (int i = 0; i < NT; i++) begin
            step();
            check("rr0_valid", c2f.C2F_ReqValidQ500H, 1);
            check("rr0_tid", c2f.C2F_ReqThreadIDQ500H, i);
        end
        step();
        set_req(0, 2'b10, 32'h2000, 32'hB0);
        step(); idle();
        step();
        for (int t = 0; t < NT; t++) set_req(t, 2'b10, 32'h3000 + t, 32'hC0 + t);
        step(); idle();
        for (int i = 0; i < NT; i++) begin
            step();
            check("rr1_tid", c2f.C2F_ReqThreadIDQ500H, order2[i]);
        end
        step(); step();

        // Single read on thread 2
        set_req(2, 2'b01, 32'h00400F00, 32'h0);
        step(); idle();
        check("rd_ready_pending", ThrReqReady, 4'b1011);
        step();
        check("rd_req_valid", c2f.C2F_ReqValidQ500H, 1);
        check("rd_req_tid", c2f.C2F_ReqThreadIDQ500H, 2);
        check("rd_req_addr", c2f.C2F_ReqAddressQ500H, 32'h00400F00);
        check("rd_outstanding", ThrOutstanding, 4'b0100);
        send_rsp(2, 2'b01, 32'hDEADBEEF);
        step(); idle();
        check("rd_rsp_valid", ThrRspValid, 4'b0100);
        check("rd_rsp_data", ThrRspData, 32'hDEADBEEF);
        check("rd_outstanding_clr", ThrOutstanding, 4'b0000);
        step();

        // Stall holds the presented request; next pending follows right after release
        do_reset();
        set_req(1, 2'b10, 32'h11, 32'h12345678);
        set_req(3, 2'b10, 32'h33, 32'hCAFE0003);
        step(); idle();
        c2f.C2F_RspStall = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            check("stall_tid", c2f.C2F_ReqThreadIDQ500H, 1);
            check("stall_data", c2f.C2F_ReqDataQ500H, 32'h12345678);
            step();
        end
        c2f.C2F_RspStall = 1'b0;
        check("stall_last_tid", c2f.C2F_ReqThreadIDQ500H, 1);
        step();
        check("stall_next_tid", c2f.C2F_ReqThreadIDQ500H, 3);
        check("stall_next_data", c2f.C2F_ReqDataQ500H, 32'hCAFE0003);

        // Spurious response and illegal opcode
        send_rsp(3, 2'b01, 32'h77);
        step(); idle();
        check("spur_flag", SpuriousRsp, 1);
        check("spur_no_rsp", ThrRspValid, 0);
        set_req(0, 2'b11, 32'h44, 32'h55);
        step(); idle();
        check("ill_ready_busy", ThrReqReady, 4'b1110);
        step();
        check("ill_no_req", c2f.C2F_ReqValidQ500H, 0);
        check("ill_ready_back", ThrReqReady, 4'hF);
        check("ill_no_outst", ThrOutstanding, 0);

        // Timeout then late delivery
        do_reset();
        set_req(0, 2'b01, 32'h80, 32'h0);
        step(); idle();
        step();
        repeat (7) step();
        check("to_before", TimeoutErr, 4'b0000);
        step();
        check("to_after", TimeoutErr, 4'b0001);
        check("to_still_outst", ThrOutstanding, 4'b0001);
        send_rsp(0, 2'b01, 32'h5A5A0000);
        step(); idle();
        check("to_late_rsp", ThrRspValid, 4'b0001);
        check("to_late_data", ThrRspData, 32'h5A5A0000);
        check("to_outst_clr", ThrOutstanding, 0);
        check("to_sticky", TimeoutErr, 4'b0001);

        // Async reset mid-stall with three pending and one outstanding
        do_reset();
        set_req(0, 2'b01, 32'h90, 32'h0);
        step(); idle();
        step();
        c2f.C2F_RspStall = 1'b1;
        for (int t = 1; t < NT; t++) set_req(t, 2'b10, 32'hA0 + t, 32'hD0 + t);
        step();
        ThrReqValid = '0;
        check("pre_rst_ready", ThrReqReady, 4'b0000);
        check("pre_rst_outst", ThrOutstanding, 4'b0001);
        do_reset();
        send_rsp(0, 2'b01, 32'h99);
        step(); idle();
        check("post_rst_spur", SpuriousRsp, 1);
        check("post_rst_no_rsp", ThrRspValid, 0);

        // Randomized traffic with periodic resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_cycle();
            if (i % 700 == 699) do_reset();
        end
        idle();
        repeat (4) step();
        check("end_req_queue_empty", exp_req.size(), 0);
        check("end_rsp_queue_empty", exp_rsp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpc_4t_c2f_arb.md
Name: gpc_4t_c2f_arb

Overview:
- Core-to-fabric (C2F) request arbiter and outstanding-read tracker for the 4-thread GPC core.
- Sits between the per-thread load/store issue logic and the gpc_4t C2F_Req*/C2F_Rsp* boundary.
- Accepts one request per thread and round-robins them onto the single C2F request channel, honouring C2F_RspStall.
- Tracks one outstanding read per thread, routes responses back by ThreadID, and flags timeouts and spurious responses.

Parameters:
NUM_THR, 4, thread count; ThreadID width is log2(NUM_THR) = 2.
ADDR_W, 32, request address width.
DATA_W, 32, request/response data width.
TIMEOUT_CYC, 1024, cycles a read may stay outstanding before TimeoutErr sets; minimum legal value is 2.

Ports:
QClk  in  1  clock; all state updates on the rising edge.
RstQnnnL  in  1  reset; asynchronous, active-low; clears all state.
ThrReqValid  in  NUM_THR  per-thread request valid.
ThrReqOpcode  in  2*NUM_THR  per-thread opcode: 2'b01 = RD, 2'b10 = WR, others illegal.
ThrReqAddress  in  ADDR_W*NUM_THR  per-thread address.
ThrReqData  in  DATA_W*NUM_THR  per-thread write data.
ThrReqReady  out  NUM_THR  thread slot can accept a request.
C2F_ReqValidQ500H  out  1  fabric request valid (registered).
C2F_ReqOpcodeQ500H  out  2  fabric request opcode.
C2F_ReqThreadIDQ500H  out  2  ThreadID of the granted thread.
C2F_ReqAddressQ500H  out  ADDR_W  fabric request address.
C2F_ReqDataQ500H  out  DATA_W  fabric request data.
C2F_RspStall  in  1  fabric cannot take a request this cycle.
C2F_RspValidQ502H  in  1  fabric response valid.
C2F_RspOpcodeQ502H  in  2  response opcode (RD only is legal).
C2F_RspThreadIDQ502H  in  2  ThreadID of the response.
C2F_RspDataQ502H  in  DATA_W  response read data.
ThrRspValid  out  NUM_THR  one-cycle per-thread read-return pulse (registered).
ThrRspData  out  DATA_W  read data, valid together with ThrRspValid.
ThrOutstanding  out  NUM_THR  read in flight per thread.
TimeoutErr  out  NUM_THR  sticky per-thread timeout flag.
SpuriousRsp  out  1  sticky flag: response for a thread with no outstanding read.

Behaviour:
- Reset: all outputs 0; Pending, Outstanding, timeout counters, error flags cleared; round-robin pointer = thread 0 (thread 0 has highest priority first).
- Reset mid-operation: request slots are lost. A response arriving after reset is counted as spurious.
- ThrReqReady[t] = ~Pending[t] & ~Outstanding[t] (combinational from state).
- Accept: when ThrReqValid[t] & ThrReqReady[t], the slot latches opcode/address/data and sets Pending[t].
- An illegal opcode is accepted, then dropped at grant with no fabric request and no outstanding set.
- Output register "free" = ~C2F_ReqValidQ500H | ~C2F_RspStall. A presented request is consumed on any cycle where C2F_ReqValidQ500H & ~C2F_RspStall.
- Grant: when the output register is free and any Pending bit is set, select the first pending thread at or after the pointer, wrapping 3 -> 0.
  - Load the output registers; clear Pending[g]; move the pointer to g+1 mod 4.
  - Set Outstanding[g] if the opcode is RD. WR is posted.
- When the output register is free and nothing is pending, C2F_ReqValidQ500H deasserts.
- Stall: while C2F_RspStall = 1 and valid = 1, all C2F_Req* outputs hold stable; no grant occurs and the pointer does not move.
- Latency: request accepted at edge N -> earliest C2F_ReqValidQ500H after edge N+1; back-to-back grants give 1 request per cycle.
- Response at edge M with ThreadID t:
  - If Outstanding[t]: ThrRspValid[t] = 1 and ThrRspData = data for the cycle after edge M; Outstanding[t] clears at edge M; ThrReqReady[t] rises after edge M.
  - Else: drop the response and set SpuriousRsp.
  - A non-RD response opcode is treated as spurious.
- Timeout counter: cleared when Outstanding[t] sets; increments each cycle while outstanding; saturates.
  - When the count reaches TIMEOUT_CYC-1, TimeoutErr[t] sets.
  - Outstanding[t] remains set; a late response is still delivered normally.
- Simultaneous events:
  - A response and a grant in the same cycle are independent; both take effect.
  - A response for t and a new ThrReqValid[t] in the same cycle: the request is not accepted that cycle, because ready reflects the pre-edge state.
- Error flags clear only on reset.

Test Plan:
- Single RD: thread 2 requests addr 0x00400F00 -> C2F_ReqValid 1 cycle later with ThreadID 2, ThrOutstanding = 4'b0100; response data 0xDEADBEEF -> ThrRspValid = 4'b0100 next cycle, ThrRspData = 0xDEADBEEF, ThrOutstanding = 0.
- Round-robin: all 4 threads issue WR in the same cycle, no stall -> grants in ThreadID order 0,1,2,3 on consecutive cycles; a repeat burst after pointer = 1 -> order 1,2,3,0.
- Stall: assert C2F_RspStall for 5 cycles with thread 1 WR 0x12345678 presented -> outputs hold for 5 cycles; consumed on the 6th; thread 3 pending is granted on the next cycle.
- Spurious/illegal: response with ThreadID 3 while no read is outstanding -> SpuriousRsp = 1, no ThrRspValid; opcode 2'b11 request -> no fabric request, ThrReqReady returns to 1.
- Timeout: TIMEOUT_CYC = 8, thread 0 RD with no response -> TimeoutErr[0] = 1 after 8 cycles outstanding; a later response is still delivered and clears Outstanding[0].
- Async reset: assert RstQnnnL = 0 mid-stall with 3 pending and 1 outstanding -> all outputs 0 immediately, independent of QClk; a subsequent response -> SpuriousRsp = 1.
